// File: rtl/regfile_mp.sv
// Parametrised 3-read/1-write register file with byte-enabled writes and a hardware clear FSM.
// Build option: define REGFILE_BYPASS_EN for write-first collisions; read-first otherwise.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     rn_a,
    input  logic [ADDR_W-1:0]     rm_a,
    input  logic [ADDR_W-1:0]     wa,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  clr,
    output logic [DATA_W-1:0]     rd_out,
    output logic [DATA_W-1:0]     rn_out,
    output logic [DATA_W-1:0]     rm_out,
    output logic                  busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                w_clr_we;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_rn_data;
    logic [DATA_W-1:0]   w_rm_data;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // FSM state, clear pointer and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state: clear sweeps every entry once; clr beats a same-cycle write
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy_nxt  = r_busy;
        w_clr_we    = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we   = 1'b1;
                w_ptr_nxt  = r_ptr + ADDR_W'(1);
                w_busy_nxt = 1'b1;
                if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = S_READY;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_READY: begin
                w_busy_nxt = 1'b0;
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_wr_en = we;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    // Old word at wa with enabled bytes replaced
    always_comb begin
        w_merged = r_mem[wa];
        for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
                w_merged[8*i +: 8] = wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[wa] <= w_merged;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        w_rd_data = w_wr_en ? w_merged : r_mem[wa];
        w_rn_data = (w_wr_en && (rn_a == wa)) ? w_merged : r_mem[rn_a];
        w_rm_data = (w_wr_en && (rm_a == wa)) ? w_merged : r_mem[rm_a];
    end
`else
    always_comb begin
        w_rd_data = r_mem[wa];
        w_rn_data = r_mem[rn_a];
        w_rm_data = r_mem[rm_a];
    end
`endif

    // Registered read ports, held at zero while clearing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_out <= '0;
            rn_out <= '0;
            rm_out <= '0;
        end else if (r_state == S_CLEAR) begin
            rd_out <= '0;
            rn_out <= '0;
            rm_out <= '0;
        end else begin
            rd_out <= w_rd_data;
            rn_out <= w_rn_data;
            rm_out <= w_rm_data;
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a reference model pushes expected read/busy values each cycle,
// which are popped and compared one edge later.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic [3:0]  rn_a;
    logic [3:0]  rm_a;
    logic [3:0]  wa;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] wd;
    logic        clr;
    logic [31:0] rd_out;
    logic [31:0] rn_out;
    logic [31:0] rm_out;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        logic        busy;
        logic [31:0] rd;
        logic [31:0] rn;
        logic [31:0] rm;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [16];
    logic        m_busy;
    logic [3:0]  m_ptr;

    regfile_mp #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .rn_a   (rn_a),
        .rm_a   (rm_a),
        .wa     (wa),
        .we     (we),
        .wbe    (wbe),
        .wd     (wd),
        .clr    (clr),
        .rd_out (rd_out),
        .rn_out (rn_out),
        .rm_out (rm_out),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] nw);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a, input logic wr,
                                               input logic [3:0] wa_i, input logic [3:0] be,
                                               input logic [31:0] nw);
        if (m_busy) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr && a == wa_i) return merge(m_mem[a], be, nw);
`endif
        return m_mem[a];
    endfunction

    // One clock: drive inputs, push model prediction, clock, pop and compare
    task automatic cycle(input string tag, input logic [3:0] rn_i, input logic [3:0] rm_i,
                         input logic [3:0] wa_i, input logic we_i, input logic [3:0] wbe_i,
                         input logic [31:0] wd_i, input logic clr_i);
        exp_t e;
        exp_t got;
        logic wr;
        rn_a = rn_i; rm_a = rm_i; wa = wa_i; we = we_i; wbe = wbe_i; wd = wd_i; clr = clr_i;
        wr     = !m_busy && !clr_i && we_i;
        e.tag  = tag;
        e.rd   = model_read(wa_i, wr, wa_i, wbe_i, wd_i);
        e.rn   = model_read(rn_i, wr, wa_i, wbe_i, wd_i);
        e.rm   = model_read(rm_i, wr, wa_i, wbe_i, wd_i);
        if (m_busy) begin
            m_mem[m_ptr] = 32'h0;
            if (m_ptr == 4'hF) m_busy = 1'b0;
            m_ptr = m_ptr + 4'd1;
        end else if (clr_i) begin
            m_busy = 1'b1;
            m_ptr  = 4'd0;
        end else if (we_i) begin
            m_mem[wa_i] = merge(m_mem[wa_i], wbe_i, wd_i);
        end
        e.busy = m_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".busy"}, 32'(busy), 32'(got.busy));
        check({got.tag, ".rd"}, rd_out, got.rd);
        check({got.tag, ".rn"}, rn_out, got.rn);
        check({got.tag, ".rm"}, rm_out, got.rm);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 4'd0, 4'd0, 4'd0, 1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        cycle("wr", 4'd0, 4'd0, a, 1'b1, be, d, 1'b0);
    endtask

    // Counts edges until busy falls, bounded
    task automatic wait_clear(input string tag, input logic drive_we);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(tag, 4'd2, 4'd2, 4'(k), drive_we, 4'hF, 32'hFFFF_FFFF, 1'b0);
            n++;
            if (!busy) break;
        end
        check({tag, ".busy_cycles"}, 32'(n), 32'd16);
    endtask

    task automatic apply_reset(input int n);
        reset  = 1'b0;
        m_busy = 1'b1;
        m_ptr  = 4'd0;
        #1;
        check("rst.busy", 32'(busy), 32'd1);
        check("rst.rn", rn_out, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        check("rst_hold.busy", 32'(busy), 32'd1);
        check("rst_hold.rd", rd_out, 32'h0);
        check("rst_hold.rm", rm_out, 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rn_a = '0; rm_a = '0; wa = '0; we = 1'b0; wbe = '0; wd = '0; clr = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
        reset = 1'b0;
        @(negedge clk);

        // T1: reset for 3 clocks, then a 16-cycle clear, then everything reads zero
        apply_reset(3);
        wait_clear("t1", 1'b0);
        for (int i = 0; i < 16; i += 2)
            cycle("t1.rd0", 4'(i), 4'(i + 1), 4'(i), 1'b0, 4'h0, 32'h0, 1'b0);

        // T2: full write then read
        wr(4'd3, 4'hF, 32'hDEAD_BEEF);
        cycle("t2", 4'd3, 4'd0, 4'd0, 1'b0, 4'h0, 32'h0, 1'b0);
        check("t2.direct", rn_out, 32'hDEAD_BEEF);

        // T3: byte-enabled merge
        wr(4'd5, 4'hF, 32'h1122_3344);
        wr(4'd5, 4'b0101, 32'hAABB_CCDD);
        cycle("t3", 4'd0, 4'd5, 4'd0, 1'b0, 4'h0, 32'h0, 1'b0);
        check("t3.direct", rm_out, 32'h11BB_33DD);
        wr(4'd5, 4'h0, 32'hFFFF_FFFF);
        cycle("t3.nobe", 4'd5, 4'd0, 4'd0, 1'b0, 4'h0, 32'h0, 1'b0);

        // T4: read/write collision on all three ports
        cycle("t4.col", 4'd7, 4'd7, 4'd7, 1'b1, 4'hF, 32'h1234_5678, 1'b0);
`ifdef REGFILE_BYPASS_EN
        check("t4.direct", rm_out, 32'h1234_5678);
`else
        check("t4.direct", rm_out, 32'h0);
`endif
        cycle("t4.next", 4'd7, 4'd7, 4'd0, 1'b0, 4'h0, 32'h0, 1'b0);
        check("t4.next_direct", rm_out, 32'h1234_5678);
        cycle("t4.part", 4'd3, 4'd7, 4'd3, 1'b1, 4'b1000, 32'h5500_0000, 1'b0);

        // T5: clr wins over a same-cycle write; writes during clear are dropped
        wr(4'd2, 4'hF, 32'h0BAD_F00D);
        cycle("t5.clr", 4'd2, 4'd2, 4'd2, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1);
        wait_clear("t5", 1'b1);
        cycle("t5.r2", 4'd2, 4'd7, 4'd3, 1'b0, 4'h0, 32'h0, 1'b0);
        check("t5.r2_direct", rn_out, 32'h0);

        // T6: reset in the middle of a clear restarts the full sweep
        wr(4'd9, 4'hF, 32'hCAFE_0009);
        cycle("t6.clr", 4'd0, 4'd0, 4'd0, 1'b0, 4'h0, 32'h0, 1'b1);
        for (int k = 0; k < 7; k++) idle("t6.pre");
        apply_reset(2);
        wait_clear("t6", 1'b0);

        // Random traffic against the model
        for (int k = 0; k < 60; k++)
            cycle("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
